// File: rtl/ddr3_pack_writer.sv
// rtl/ddr3_pack_writer.sv - loader word stream to MIG write beats with CDC FIFO, packing and masks
//
// Crosses DW-bit loader words from wr_clk into ui_clk through a gray-pointer
// async FIFO, packs LANES = APP_DW/DW words per beat (lane 0 in the LSBs) and
// drives MIG write commands with independent command and data handshakes.
//
// Ports
//   ui_clk, rst_n                    MIG clock, synchronous active-low reset
//   wr_clk, wr_en, wr_data, wr_full  loader-side FIFO write port
//   start, flush, addr_base,         run control; base/limit sampled on start
//   addr_limit
//   busy, done, overflow, beat_count status
//   app_rdy, app_en, app_cmd,        MIG command channel
//   app_addr
//   app_wdf_rdy, app_wdf_wren,       MIG write-data channel
//   app_wdf_end, app_wdf_data,
//   app_wdf_mask
module ddr3_pack_writer #(
  parameter int DW         = 16,
  parameter int APP_DW     = 128,
  parameter int ADDR_W     = 33,
  parameter int ADDR_STEP  = 8,
  parameter int FIFO_ASIZE = 4
) (
  input  logic                ui_clk,
  input  logic                rst_n,
  input  logic                wr_clk,
  input  logic                wr_en,
  input  logic [DW-1:0]       wr_data,
  output logic                wr_full,
  input  logic                start,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   addr_base,
  input  logic [ADDR_W-1:0]   addr_limit,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [31:0]         beat_count,
  input  logic                app_rdy,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [ADDR_W-1:0]   app_addr,
  input  logic                app_wdf_rdy,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [APP_DW-1:0]   app_wdf_data,
  output logic [APP_DW/8-1:0] app_wdf_mask
);

  localparam int LANES = APP_DW / DW;
  localparam int BPL   = DW / 8;
  localparam int MW    = APP_DW / 8;
  localparam int LW    = $clog2(LANES + 1);
  localparam int AW    = FIFO_ASIZE;
  localparam int DEPTH = 1 << AW;

  // ---------------- async FIFO, write side (wr_clk) ----------------
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wbin, r_wgray, r_wq1_rgray, r_wq2_rgray;
  logic          r_wfull;
  logic          w_wpush, w_wfull_nx;
  logic [AW:0]   w_wbin_nx, w_wgray_nx;

  assign w_wpush    = wr_en & ~r_wfull;
  assign w_wbin_nx  = r_wbin + {{AW{1'b0}}, w_wpush};
  assign w_wgray_nx = (w_wbin_nx >> 1) ^ w_wbin_nx;
  // Full when the write pointer has lapped the synchronised read pointer.
  assign w_wfull_nx = (w_wgray_nx == {~r_wq2_rgray[AW:AW-1], r_wq2_rgray[AW-2:0]});
  assign wr_full    = r_wfull;

  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      r_wbin      <= '0;
      r_wgray     <= '0;
      r_wq1_rgray <= '0;
      r_wq2_rgray <= '0;
      r_wfull     <= 1'b0;
    end else begin
      r_wbin      <= w_wbin_nx;
      r_wgray     <= w_wgray_nx;
      r_wq1_rgray <= r_rgray;
      r_wq2_rgray <= r_wq1_rgray;
      r_wfull     <= w_wfull_nx;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (w_wpush) r_mem[r_wbin[AW-1:0]] <= wr_data;
  end

  // ---------------- async FIFO, read side (ui_clk) ----------------
  logic [AW:0]   r_rbin, r_rgray, r_rq1_wgray, r_rq2_wgray;
  logic          r_rempty;
  logic          w_pop, w_rempty_nx;
  logic [AW:0]   w_rbin_nx, w_rgray_nx;
  logic [DW-1:0] w_rdata;

  assign w_rbin_nx   = r_rbin + {{AW{1'b0}}, w_pop};
  assign w_rgray_nx  = (w_rbin_nx >> 1) ^ w_rbin_nx;
  assign w_rempty_nx = (w_rgray_nx == r_rq2_wgray);
  assign w_rdata     = r_mem[r_rbin[AW-1:0]];

  always_ff @(posedge ui_clk) begin
    if (!rst_n) begin
      r_rbin      <= '0;
      r_rgray     <= '0;
      r_rq1_wgray <= '0;
      r_rq2_wgray <= '0;
      r_rempty    <= 1'b1;
    end else begin
      r_rbin      <= w_rbin_nx;
      r_rgray     <= w_rgray_nx;
      r_rq1_wgray <= r_wgray;
      r_rq2_wgray <= r_rq1_wgray;
      r_rempty    <= w_rempty_nx;
    end
  end

  // ---------------- control FSM ----------------
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_FIN} state_t;
  state_t r_state, w_state_nx;

  logic [LW-1:0]     r_lane, w_lanes_nx;
  logic [APP_DW-1:0] r_pack, w_merged;
  logic [MW-1:0]     w_mask;
  logic [ADDR_W-1:0] r_cur_addr, r_limit;
  logic              r_app_en, r_wdf_wren, r_overflow;
  logic [ADDR_W-1:0] r_addr;
  logic [APP_DW-1:0] r_data;
  logic [MW-1:0]     r_mask;
  logic [31:0]       r_beat_count;
  logic              w_active, w_out_free, w_flush_tail, w_xfer, w_in_window, w_complete;

  assign w_active     = (r_state == S_RUN) | (r_state == S_FLUSH);
  assign w_pop        = w_active & ~r_rempty & (r_lane != LW'(LANES));
  assign w_lanes_nx   = r_lane + {{(LW-1){1'b0}}, w_pop};
  // Output register is free after this edge if each channel is idle or retiring now.
  assign w_out_free   = (~r_app_en | app_rdy) & (~r_wdf_wren | app_wdf_rdy);
  assign w_flush_tail = (r_state == S_FLUSH) & r_rempty & (r_lane != '0);
  // The word completing a beat bypasses straight into the output register,
  // which keeps the packer popping one word every cycle.
  assign w_xfer       = w_out_free & ((w_lanes_nx == LW'(LANES)) | w_flush_tail);
  assign w_in_window  = (r_cur_addr < r_limit);
  assign w_complete   = (r_app_en | r_wdf_wren) & w_out_free;

  always_comb begin
    w_merged = r_pack;
    w_mask   = '1;
    for (int i = 0; i < LANES; i++) begin
      if (w_pop && (r_lane == LW'(i))) w_merged[i*DW +: DW] = w_rdata;
      if (LW'(i) < w_lanes_nx) w_mask[i*BPL +: BPL] = '0;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = S_RUN;
      S_RUN:   if (flush) w_state_nx = S_FLUSH;
      S_FLUSH: if (r_rempty && (r_lane == '0) && !r_app_en && !r_wdf_wren) w_state_nx = S_FIN;
      S_FIN:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lane       <= '0;
      r_pack       <= '0;
      r_cur_addr   <= '0;
      r_limit      <= '0;
      r_overflow   <= 1'b0;
      r_beat_count <= '0;
      r_app_en     <= 1'b0;
      r_wdf_wren   <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_mask       <= '1;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_IDLE && start) begin
        r_cur_addr   <= addr_base;
        r_limit      <= addr_limit;
        r_overflow   <= 1'b0;
        r_beat_count <= '0;
        r_lane       <= '0;
        r_pack       <= '0;
      end else begin
        if (w_xfer) begin
          r_lane <= '0;
          r_pack <= '0;
          if (w_in_window) r_cur_addr <= r_cur_addr + ADDR_W'(ADDR_STEP);
          else             r_overflow <= 1'b1;
        end else if (w_pop) begin
          r_lane <= w_lanes_nx;
          r_pack <= w_merged;
        end
        if (w_complete) r_beat_count <= r_beat_count + 32'd1;
      end
      if (w_xfer && w_in_window) begin
        r_app_en   <= 1'b1;
        r_wdf_wren <= 1'b1;
        r_addr     <= r_cur_addr;
        r_data     <= w_merged;
        r_mask     <= w_mask;
      end else begin
        if (r_app_en && app_rdy)       r_app_en   <= 1'b0;
        if (r_wdf_wren && app_wdf_rdy) r_wdf_wren <= 1'b0;
      end
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_FIN);
  assign overflow     = r_overflow;
  assign beat_count   = r_beat_count;
  assign app_en       = r_app_en;
  assign app_cmd      = 3'b000;
  assign app_addr     = r_addr;
  assign app_wdf_wren = r_wdf_wren;
  assign app_wdf_end  = r_wdf_wren;
  assign app_wdf_data = r_data;
  assign app_wdf_mask = r_mask;

endmodule

// File: tb/tb_ddr3_pack_writer.sv
// tb/tb_ddr3_pack_writer.sv - scoreboard bench for ddr3_pack_writer
module tb_ddr3_pack_writer;

  logic         ui_clk = 1'b0, wr_clk = 1'b0, rst_n = 1'b0;
  logic         wr_en = 1'b0, wr_full;
  logic [15:0]  wr_data = '0;
  logic         start = 1'b0, flush = 1'b0;
  logic [32:0]  addr_base = '0, addr_limit = '0;
  logic         busy, done, overflow;
  logic [31:0]  beat_count;
  logic         app_rdy = 1'b1, app_en, app_wdf_rdy = 1'b1, app_wdf_wren, app_wdf_end;
  logic [2:0]   app_cmd;
  logic [32:0]  app_addr;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;

  ddr3_pack_writer dut (
    .ui_clk(ui_clk), .rst_n(rst_n), .wr_clk(wr_clk), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .start(start), .flush(flush), .addr_base(addr_base),
    .addr_limit(addr_limit), .busy(busy), .done(done), .overflow(overflow),
    .beat_count(beat_count), .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd),
    .app_addr(app_addr), .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask)
  );

  always #5  ui_clk = ~ui_clk;
  always #10 wr_clk = ~wr_clk;

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, en_cycles = 0;
  logic [32:0]  exp_addr_q[$];
  logic [127:0] exp_data_q[$];
  logic [15:0]  exp_mask_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] bytes_of(input logic [15:0] m);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = m[i] ? 8'h00 : 8'hFF;
    return r;
  endfunction

  task automatic expect_beat(input logic [32:0] a, input logic [127:0] d, input logic [15:0] m);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
    exp_mask_q.push_back(m);
  endtask

  // Monitor: pops the scoreboard whenever a channel retires.
  always @(negedge ui_clk) begin
    if (rst_n) begin
      if (app_en) en_cycles++;
      if (done) done_cnt++;
      if (app_en && app_rdy) begin
        if (exp_addr_q.size() == 0) chk("unexpected_cmd", 1, 0);
        else chk("app_addr", app_addr, exp_addr_q.pop_front());
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (exp_data_q.size() == 0) chk("unexpected_data", 1, 0);
        else begin
          logic [127:0] ed;
          logic [15:0]  em;
          ed = exp_data_q.pop_front();
          em = exp_mask_q.pop_front();
          chk("app_wdf_mask", app_wdf_mask, em);
          chk("app_wdf_data", app_wdf_data & bytes_of(em), ed & bytes_of(em));
          chk("app_wdf_end", app_wdf_end, 1);
        end
      end
    end
  end

  task automatic write_word(input logic [15:0] w);
    int t = 0;
    @(negedge wr_clk);
    while (wr_full && t < 200) begin @(negedge wr_clk); t++; end
    if (t >= 200) chk("wr_full_timeout", 1, 0);
    wr_en = 1'b1;
    wr_data = w;
    @(negedge wr_clk);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [32:0] b, input logic [32:0] l);
    @(negedge ui_clk);
    addr_base = b;
    addr_limit = l;
    start = 1'b1;
    @(negedge ui_clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_run(input string tag);
    int d0, t;
    repeat (10) @(negedge ui_clk);
    d0 = done_cnt;
    flush = 1'b1;
    @(negedge ui_clk);
    flush = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 1000) begin @(negedge ui_clk); t++; end
    repeat (3) @(negedge ui_clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic wait_app_en(input string tag);
    int t = 0;
    while (!app_en && t < 500) begin @(negedge ui_clk); t++; end
    if (t >= 500) chk({tag, "_app_en_timeout"}, 1, 0);
  endtask

  initial begin
    int e0;
    logic seen_full;
    logic [127:0] d;

    // Reset state
    repeat (5) @(negedge ui_clk);
    rst_n = 1'b1;
    @(negedge ui_clk);
    chk("rst_app_en", app_en, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mask", app_wdf_mask, 16'hFFFF);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_wr_full", wr_full, 0);
    chk("rst_app_cmd", app_cmd, 0);

    // Full beats
    do_start(33'h100, 33'h200);
    expect_beat(33'h100, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 16'h0000);
    expect_beat(33'h108, 128'h0010_000F_000E_000D_000C_000B_000A_0009, 16'h0000);
    e0 = en_cycles;
    for (int i = 1; i <= 16; i++) write_word(16'(i));
    finish_run("full");
    chk("full_beat_count", beat_count, 2);
    chk("full_en_cycles", en_cycles - e0, 2);

    // Partial flush
    do_start(33'h300, 33'h400);
    expect_beat(33'h300, {80'h0, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 16'hFFC0);
    write_word(16'hAAAA);
    write_word(16'hBBBB);
    write_word(16'hCCCC);
    finish_run("partial");
    chk("partial_beat_count", beat_count, 1);

    // Split handshake: command stalled, data retires first
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b1;
    expect_beat(33'h000, 128'h1008_1007_1006_1005_1004_1003_1002_1001, 16'h0000);
    expect_beat(33'h008, 128'h1010_100F_100E_100D_100C_100B_100A_1009, 16'h0000);
    for (int i = 1; i <= 16; i++) write_word(16'h1000 + 16'(i));
    do_start(33'h000, 33'h1000);
    wait_app_en("splitA");
    for (int k = 0; k < 12; k++) begin
      @(negedge ui_clk);
      chk("splitA_app_en_held", app_en, 1);
      chk("splitA_addr_stable", app_addr, 33'h000);
      chk("splitA_no_next_beat", app_wdf_wren, 0);
    end
    app_rdy = 1'b1;
    finish_run("splitA");
    chk("splitA_beat_count", beat_count, 2);

    // Split handshake: data stalled, command retires first
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b0;
    expect_beat(33'h000, 128'h2008_2007_2006_2005_2004_2003_2002_2001, 16'h0000);
    expect_beat(33'h008, 128'h2010_200F_200E_200D_200C_200B_200A_2009, 16'h0000);
    for (int i = 1; i <= 16; i++) write_word(16'h2000 + 16'(i));
    do_start(33'h000, 33'h1000);
    wait_app_en("splitB");
    for (int k = 0; k < 12; k++) begin
      @(negedge ui_clk);
      chk("splitB_wren_held", app_wdf_wren, 1);
      chk("splitB_data_stable", app_wdf_data, 128'h2008_2007_2006_2005_2004_2003_2002_2001);
      chk("splitB_no_next_beat", app_en, 0);
    end
    app_wdf_rdy = 1'b1;
    finish_run("splitB");
    chk("splitB_beat_count", beat_count, 2);

    // Address limit
    do_start(33'h1F8, 33'h200);
    expect_beat(33'h1F8, 128'h3008_3007_3006_3005_3004_3003_3002_3001, 16'h0000);
    for (int i = 1; i <= 24; i++) write_word(16'h3000 + 16'(i));
    finish_run("limit");
    chk("limit_overflow", overflow, 1);
    chk("limit_beat_count", beat_count, 1);
    do_start(33'h0, 33'h1000);
    chk("limit_overflow_cleared", overflow, 0);
    finish_run("limit_restart");

    // Back-pressure across the clock crossing
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    for (int j = 0; j < 8; j++) begin
      for (int l = 0; l < 8; l++) d[l*16 +: 16] = 16'h5000 + 16'(8*j + l);
      expect_beat(33'h2000 + 33'(8*j), d, 16'h0000);
    end
    do_start(33'h2000, 33'h10000);
    seen_full = 1'b0;
    fork
      begin
        int acc = 0, att = 0;
        while (acc < 64 && att < 2000) begin
          @(negedge wr_clk);
          wr_en = 1'b1;
          wr_data = 16'h5000 + 16'(acc);
          if (wr_full) seen_full = 1'b1;
          else acc++;
          att++;
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
        if (acc < 64) chk("cdc_writer_timeout", acc, 64);
      end
      begin
        repeat (100) @(negedge ui_clk);
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
      end
    join
    chk("cdc_wr_full_seen", seen_full, 1);
    finish_run("cdc");
    chk("cdc_beat_count", beat_count, 8);
    chk("scoreboard_drained", exp_addr_q.size() + exp_data_q.size(), 0);

    // Reset while a command is in flight
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    do_start(33'h40, 33'h1000);
    for (int i = 1; i <= 8; i++) write_word(16'h6000 + 16'(i));
    wait_app_en("rst_mid");
    @(negedge ui_clk);
    rst_n = 1'b0;
    @(negedge ui_clk);
    chk("rstmid_app_en", app_en, 0);
    chk("rstmid_wren", app_wdf_wren, 0);
    chk("rstmid_end", app_wdf_end, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_overflow", overflow, 0);
    chk("rstmid_addr", app_addr, 0);
    chk("rstmid_data", app_wdf_data, 0);
    chk("rstmid_mask", app_wdf_mask, 16'hFFFF);
    chk("rstmid_beat_count", beat_count, 0);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
